inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage that sits directly upstream of the instruction controller/decoder. Holds a small word-addressed instruction memory and a program counter, and presents one 32-bit instruction per cycle with a valid flag. The 32-bit instruction layout is MUXsel[31], rd[30:25], rs[24:19], ALUopsel[18:15], rt[14:9], imm[8:0]. The stage supports downstream stall, PC redirect (branch/jump), program loading while idle, and halt detection.

## Interface
- DEPTH, 64, instruction memory depth in 32-bit words (power of two)
- ADDR_W, 6, PC/address width, equal to log2(DEPTH)
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  single-cycle pulse; begins fetching at PC 0 from IDLE or HALT
- stall  input  1  downstream hold; freezes PC and output registers
- redirect_valid  input  1  load PC from redirect_pc
- redirect_pc  input  ADDR_W  redirect target
- prog_we  input  1  instruction memory write enable
- prog_addr  input  ADDR_W  memory write address
- prog_data  input  32  memory write data
- inst  output  32  fetched instruction to decoder
- inst_valid  output  1  inst is a real instruction this cycle
- pc_out  output  ADDR_W  address that inst was fetched from
- busy  output  1  high while in FETCH
- halted  output  1  high while in HALT

## Operation
- States: IDLE, FETCH, HALT.
- IDLE: no fetch. busy=0, inst_valid=0. start=1 moves to FETCH with pc=0.
- FETCH, no stall, no redirect: inst<=mem[pc], pc_out<=pc, inst_valid<=1, pc<=pc+1.
- PC arithmetic is modulo DEPTH. PC DEPTH-1 wraps to 0; wrap is not a halt.
- stall=1 in FETCH: pc, inst, pc_out and inst_valid hold their values.
- redirect_valid=1 in FETCH: pc<=redirect_pc and inst_valid<=0 (one bubble), whatever the value of stall. Redirect beats stall. Next unstalled cycle fetches mem[redirect_pc].
- Halt word 32'hFFFF_FFFF fetched (with IFETCH_HALT_EN):
  - Not presented downstream: inst_valid<=0, inst holds its previous value.
  - State moves to HALT and pc stops at the halt word address.
- HALT: halted=1, busy=0, inst_valid=0. start=1 returns to FETCH with pc=0.
- redirect_valid and stall are ignored in IDLE and HALT.
- prog_we is accepted only in IDLE or HALT: mem[prog_addr]<=prog_data. It is ignored in FETCH.
- start while already in FETCH is ignored.
- Reset values:
  - state=IDLE, pc=0, inst=0, inst_valid=0, pc_out=0, busy=0, halted=0.
  - Memory contents are not reset.
- rst_n low in mid-FETCH aborts on that edge. Any in-flight instruction is dropped (inst_valid=0 next cycle).

## Timing
- Fetch latency: 1 cycle. pc sampled at edge N appears on inst/pc_out after edge N.
- First valid instruction: the cycle after the edge that follows the start edge (start edge sets pc=0).
- Throughput: one instruction per unstalled cycle.
- Redirect cost: exactly one bubble cycle.
- A write to address A at edge N is visible to a fetch of A at any later edge.
- busy and halted are registered and change on the same edge as the state.

## Configuration
- IFETCH_HALT_EN defined: halt-word detection is active, as described above.
- IFETCH_HALT_EN undefined:
  - 32'hFFFF_FFFF is an ordinary instruction and is presented with inst_valid=1.
  - HALT is unreachable and halted is tied 0.
  - FETCH runs until reset.

## Test plan
- Load mem[0..3]=32'h0000_8001, 32'h0201_0003, 32'h8408_8005, 32'hFFFF_FFFF, then pulse start -> inst_valid high for 3 cycles with pc_out 0, 1, 2 and the matching words; then halted=1, inst_valid=0, pc=3 (macro on).
- Stall for 2 cycles while pc_out=1 is presented -> inst and pc_out hold 32'h0201_0003/1 for 3 cycles total; fetch resumes at 2 with no skipped or duplicated word.
- redirect_valid=1, redirect_pc=10 together with stall=1 -> inst_valid=0 for one cycle, then inst=mem[10] and pc_out=10.
- DEPTH=64 with no halt words, start redirected to 62 -> pc_out sequence 62, 63, 0, 1; halted stays 0.
- prog_we=1 during FETCH to addr 5 with data 32'h1234_5678 -> mem[5] unchanged; the same write in HALT updates mem[5], and restart shows the new word at pc_out=5.
- rst_n=0 for one cycle mid-FETCH -> next cycle inst=0, inst_valid=0, pc_out=0, busy=0, state IDLE.

Source files
------------

// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch stage. Holds a small word-addressed instruction
//            memory and a program counter, and presents one 32-bit instruction
//            per cycle with a valid flag. Supports downstream stall, PC
//            redirect, program loading while idle/halted and halt detection.
//            Instruction layout: MUXsel[31] rd[30:25] rs[24:19]
//            ALUopsel[18:15] rt[14:9] imm[8:0].
// Options  : IFETCH_HALT_EN - when defined, fetching 32'hFFFF_FFFF stops the
//            stage in HALT instead of presenting the word downstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       fetch_word;
  logic              is_halt;

  assign fetch_word = mem[pc];

`ifdef IFETCH_HALT_EN
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  assign is_halt = (fetch_word == HALT_WORD);
`else
  // Without halt detection every word, including all-ones, is an instruction.
  assign is_halt = 1'b0;
`endif

  // Program load port: writes only land while the stage is not fetching.
  always_ff @(posedge clk) begin
    if (prog_we && (state != S_FETCH)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Fetch control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      pc_out     <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          inst_valid <= 1'b0;
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          if (redirect_valid) begin
            // Redirect wins over stall and costs exactly one bubble.
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
          end else if (!stall) begin
            if (is_halt) begin
              // Halt word is swallowed; pc parks on its address.
              inst_valid <= 1'b0;
              state      <= S_HALT;
              busy       <= 1'b0;
              halted     <= 1'b1;
            end else begin
              inst       <= fetch_word;
              pc_out     <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + ADDR_W'(1);
            end
          end
        end

        S_HALT: begin
          inst_valid <= 1'b0;
          if (start) begin
            state  <= S_FETCH;
            pc     <= '0;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end

        default: begin
          state      <= S_IDLE;
          inst_valid <= 1'b0;
          busy       <= 1'b0;
          halted     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch (table-driven vectors plus
//            hand-written multi-cycle sequences). Expectations follow the
//            IFETCH_HALT_EN setting of the build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic [31:0]       inst;
  logic              inst_valid;
  logic [ADDR_W-1:0] pc_out;
  logic              busy;
  logic              halted;

  int n_cmp  = 0;
  int n_fail = 0;

  inst_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .pc_out         (pc_out),
    .busy           (busy),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stall;
    logic        rv;
    logic [5:0]  rpc;
    logic        chk_data;
    logic        valid;
    logic [31:0] inst;
    logic [5:0]  pc_out;
    logic        busy;
    logic        halted;
  } vec_t;

  vec_t vec [32];
  int   n_vec;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
  endtask

  function automatic logic [31:0] word_at(input int a);
    case (a)
      0: return 32'h0000_8001;
      1: return 32'h0201_0003;
      2: return 32'h8408_8005;
      3: return 32'hFFFF_FFFF;
      default: return 32'hA000_0000 | 32'(a);
    endcase
  endfunction

  task automatic add(input logic s, input logic st, input logic rv, input logic [5:0] rpc,
                     input logic cd, input logic v, input logic [31:0] i, input logic [5:0] po,
                     input logic b, input logic h);
    vec[n_vec] = '{s, st, rv, rpc, cd, v, i, po, b, h};
    n_vec++;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_pc_out", {26'b0, pc_out}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);

    // Load program while idle
    for (int a = 0; a < DEPTH; a++) begin
      prog_we = 1'b1; prog_addr = 6'(a); prog_data = word_at(a);
      tick();
    end
    idle_inputs();

    // Vector table: start, stall, redirect, wrap
    n_vec = 0;
    add(1, 0, 0, 0,  1, 0, 32'h0,         0, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(0),    0, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(1),    1, 1, 0);
    add(0, 1, 0, 0,  1, 1, word_at(1),    1, 1, 0);
    add(0, 1, 0, 0,  1, 1, word_at(1),    1, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(2),    2, 1, 0);
`ifdef IFETCH_HALT_EN
    add(0, 0, 0, 0,  1, 0, word_at(2),    2, 0, 1);
    add(0, 1, 1, 10, 1, 0, word_at(2),    2, 0, 1);
    add(1, 0, 0, 0,  1, 0, word_at(2),    2, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(0),    0, 1, 0);
`else
    add(0, 0, 0, 0,  1, 1, 32'hFFFF_FFFF, 3, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(4),    4, 1, 0);
    add(1, 0, 0, 0,  1, 1, word_at(5),    5, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(6),    6, 1, 0);
`endif
    add(0, 1, 1, 10, 0, 0, 32'h0,         0, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(10),  10, 1, 0);
    add(0, 0, 1, 62, 0, 0, 32'h0,         0, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(62),  62, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(63),  63, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(0),    0, 1, 0);
    add(0, 0, 0, 0,  1, 1, word_at(1),    1, 1, 0);

    for (int k = 0; k < n_vec; k++) begin
      start = vec[k].start; stall = vec[k].stall;
      redirect_valid = vec[k].rv; redirect_pc = vec[k].rpc;
      tick();
      idle_inputs();
      chk($sformatf("vec%0d_valid", k), {31'b0, inst_valid}, {31'b0, vec[k].valid});
      chk($sformatf("vec%0d_busy", k), {31'b0, busy}, {31'b0, vec[k].busy});
      chk($sformatf("vec%0d_halted", k), {31'b0, halted}, {31'b0, vec[k].halted});
      if (vec[k].chk_data) begin
        chk($sformatf("vec%0d_inst", k), inst, vec[k].inst);
        chk($sformatf("vec%0d_pc_out", k), {26'b0, pc_out}, {26'b0, vec[k].pc_out});
      end
    end

    // Write during FETCH must be dropped
    prog_we = 1'b1; prog_addr = 6'd5; prog_data = 32'h1234_5678;
    tick();
    idle_inputs();
    redirect_valid = 1'b1; redirect_pc = 6'd5;
    tick();
    idle_inputs();
    tick();
    chk("fetch_wr_inst", inst, word_at(5));
    chk("fetch_wr_pc_out", {26'b0, pc_out}, 32'd5);

`ifdef IFETCH_HALT_EN
    // Reach HALT through the halt word at address 3, pc parks there
    redirect_valid = 1'b1; redirect_pc = 6'd3;
    tick();
    idle_inputs();
    tick();
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_valid", {31'b0, inst_valid}, 32'd0);
    chk("halt_pc", {26'b0, dut.pc}, 32'd3);
`else
    // No halt state available: return to IDLE through reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("nohalt_halted", {31'b0, halted}, 32'd0);
`endif
    // Write accepted while not fetching
    prog_we = 1'b1; prog_addr = 6'd5; prog_data = 32'h1234_5678;
    tick();
    idle_inputs();
    start = 1'b1;
    tick();
    idle_inputs();
    redirect_valid = 1'b1; redirect_pc = 6'd5;
    tick();
    idle_inputs();
    tick();
    chk("idle_wr_inst", inst, 32'h1234_5678);
    chk("idle_wr_pc_out", {26'b0, pc_out}, 32'd5);
    chk("idle_wr_valid", {31'b0, inst_valid}, 32'd1);

    // Reset mid-FETCH drops the in-flight instruction
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_valid", {31'b0, inst_valid}, 32'd0);
    chk("midrst_pc_out", {26'b0, pc_out}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("midrst_idle_valid", {31'b0, inst_valid}, 32'd0);
    chk("midrst_idle_busy", {31'b0, busy}, 32'd0);

    // Memory survives reset
    start = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("mem_keep_inst", inst, word_at(0));
    chk("mem_keep_valid", {31'b0, inst_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
